dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the pipelined RISC-V core's memory stage, and a DMA/loader master used for program/data preload and debug access.
- Sits between the core/DMA and dmem; drives dmem's write-enable, address and write-data lines.
- Stalls the core whenever the DMA owns the port.
- Core has priority, with a starvation guard and bounded DMA bursts.

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core memory stage vs DMA/loader master.
// Core has priority. The DMA is force-granted after STARVE_LIMIT lost
// cycles, and a DMA burst is capped at BURST_MAX back-to-back beats.
// Ports:
//   clk, reset (async, active-low)
//   core_*     core M-stage request / store data / load data / stall
//   dma_*      DMA beat request / write data / last / grant / read data
//   mem_*      to/from dmem (combinational read)
//   dma_owner  high while a DMA burst owns the port
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dma_owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [0:0] ST_CORE = 1'b0;
  localparam logic [0:0] ST_DMA  = 1'b1;

  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
  localparam logic [BW-1:0] BONE = BW'(1);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] beat_q, beat_d;

  logic in_burst;
  logic starved;
  logic dma_win;
  logic core_win;
  logic burst_end;

  assign in_burst = (state_q == ST_DMA);
  assign starved  = (starve_q == SLIM);

  // Qualify with reset so nothing is granted or
  // written while reset is held low.
  assign dma_win = reset & dma_req &
                   (in_burst | ~core_req | starved);
  assign core_win = reset & core_req & ~dma_win;

  assign burst_end = dma_last |
                     ((beat_q + BONE) == BMAX);

  assign dma_gnt    = dma_win;
  assign core_stall = reset & core_req & ~core_win;
  assign dma_owner  = reset & in_burst;

  assign mem_we    = dma_win ? dma_we
                             : (core_win & core_we);
  assign mem_addr  = dma_win ? dma_addr : core_addr;
  assign mem_wdata = dma_win ? dma_wdata : core_wdata;

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;

    if (dma_win) begin
      starve_d = '0;
    end else if (dma_req && !starved) begin
      starve_d = starve_q + 1'b1;
    end

    unique case (1'b1)
      !in_burst: begin
        if (dma_win && !dma_last && BURST_MAX > 1) begin
          state_d = ST_DMA;
          beat_d  = BONE;
        end
      end
      in_burst: begin
        // Dropped request abandons the burst;
        // last beat or cap returns to the core.
        if (!dma_req || burst_end) begin
          state_d = ST_CORE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BONE;
        end
      end
      default: begin
        state_d = ST_CORE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_CORE;
      starve_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int SL = 4;
  localparam int BM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        dma_req, dma_we, dma_last, dma_gnt;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dma_owner;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem [256] = '{default: 32'h0};
  logic [31:0] rmem [256] = '{default: 32'h0};

  dmem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_owner(dma_owner)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the port, how long the DMA has
  // been waiting, and how many beats the current burst has taken.
  bit m_burst = 0;
  int m_wait  = 0;
  int m_beats = 0;

  always @(negedge clk) begin : compare
    bit dg, cg, we;
    logic [31:0] a;
    if (!reset) begin
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_dma_gnt", {31'b0, dma_gnt}, 0);
      chk("rst_stall", {31'b0, core_stall}, 0);
      chk("rst_owner", {31'b0, dma_owner}, 0);
      m_burst = 0;
      m_wait  = 0;
      m_beats = 0;
    end else begin
      if (m_burst) dg = dma_req;
      else dg = dma_req && (!core_req || m_wait >= SL);
      cg = core_req && !dg;
      we = dg ? dma_we : (cg && core_we);
      a  = dg ? dma_addr : core_addr;
      chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, dg});
      chk("core_stall", {31'b0, core_stall},
          {31'b0, core_req && !cg});
      chk("dma_owner", {31'b0, dma_owner}, {31'b0, m_burst});
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("mem_addr", mem_addr, a);
      if (we)
        chk("mem_wdata", mem_wdata,
            dg ? dma_wdata : core_wdata);
      if (cg && !core_we)
        chk("core_load", core_rdata, rmem[a[9:2]]);
      if (dg && !dma_we)
        chk("dma_read", dma_rdata, rmem[a[9:2]]);
      if (we) rmem[a[9:2]] = dg ? dma_wdata : core_wdata;
      if (dg) m_wait = 0;
      else if (dma_req) m_wait = (m_wait < SL) ? m_wait + 1 : SL;
      if (dg) begin
        m_beats++;
        if (dma_last || m_beats == BM) begin
          m_burst = 0;
          m_beats = 0;
        end else begin
          m_burst = 1;
        end
      end else if (m_burst) begin
        m_burst = 0;
        m_beats = 0;
      end
    end
  end

  task automatic drv(input bit cr, input bit cw,
                     input logic [31:0] ca,
                     input logic [31:0] cd,
                     input bit dr, input bit dw,
                     input logic [31:0] da,
                     input logic [31:0] dd,
                     input bit dl);
    core_req = cr; core_we = cw;
    core_addr = ca; core_wdata = cd;
    dma_req = dr; dma_we = dw;
    dma_addr = da; dma_wdata = dd;
    dma_last = dl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  logic [16:0] cut_pat;
  logic [9:0]  st_pat;

  initial begin
    st_pat  = 10'b1000010000;
    cut_pat = 17'b1_0000_11111111_0000;

    reset = 1'b0;
    drv(1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2, 0);
    settle;
    chk("L_rst_we", {31'b0, mem_we}, 0);
    chk("L_rst_stall", {31'b0, core_stall}, 0);
    chk("L_rst_gnt", {31'b0, dma_gnt}, 0);

    step;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("L_idle_we", {31'b0, mem_we}, 0);
    chk("L_idle_owner", {31'b0, dma_owner}, 0);

    step;
    drv(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    settle;
    chk("L_st_we", {31'b0, mem_we}, 1);
    chk("L_st_stall", {31'b0, core_stall}, 0);
    step;
    drv(1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
    settle;
    chk("L_ld_we", {31'b0, mem_we}, 0);
    chk("L_ld_data", core_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 10; i++) begin
      step;
      drv(1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 1);
      settle;
      chk("L_starve_gnt", {31'b0, dma_gnt}, {31'b0, st_pat[i]});
      chk("L_starve_stall", {31'b0, core_stall},
          {31'b0, st_pat[i]});
    end

    for (int i = 0; i < 3; i++) begin
      step;
      drv(0, 0, 0, 0, 1, 1, 32'h200 + 32'(4 * i),
          32'hA000_0000 + 32'(i), i == 2);
      settle;
      chk("L_burst_gnt", {31'b0, dma_gnt}, 1);
      chk("L_burst_owner", {31'b0, dma_owner}, {31'b0, i != 0});
    end
    step;
    drv(1, 0, 32'h204, 0, 0, 0, 0, 0, 0);
    settle;
    chk("L_burst_exit", {31'b0, dma_owner}, 0);
    chk("L_burst_rb", core_rdata, 32'hA000_0001);

    for (int i = 0; i < 17; i++) begin
      step;
      drv(1, 0, 32'h100, 0, 1, 0, 32'h208, 0, 0);
      settle;
      chk("L_cut_gnt", {31'b0, dma_gnt}, {31'b0, cut_pat[i]});
      chk("L_cut_stall", {31'b0, core_stall},
          {31'b0, cut_pat[i]});
    end
    step;
    drv(1, 0, 32'h100, 0, 1, 0, 32'h208, 0, 0);
    settle;
    chk("L_ab_beat2", {31'b0, dma_owner}, 1);
    step;
    drv(1, 1, 32'h300, 32'h5555, 0, 0, 0, 0, 0);
    settle;
    chk("L_ab_stall", {31'b0, core_stall}, 0);
    chk("L_ab_we", {31'b0, mem_we}, 1);
    step;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("L_ab_owner", {31'b0, dma_owner}, 0);

    for (int i = 0; i < 2; i++) begin
      step;
      drv(0, 0, 0, 0, 1, 1, 32'h3F0, 32'h77, 0);
    end
    settle;
    chk("L_mid_owner", {31'b0, dma_owner}, 1);
    step;
    reset = 1'b0;
    settle;
    chk("L_mid_we", {31'b0, mem_we}, 0);
    chk("L_mid_owner0", {31'b0, dma_owner}, 0);
    step;
    reset = 1'b1;
    drv(1, 0, 32'h3F0, 0, 1, 0, 32'h3F0, 0, 0);
    settle;
    chk("L_post_stall", {31'b0, core_stall}, 0);
    chk("L_post_gnt", {31'b0, dma_gnt}, 0);

    for (int i = 0; i < 3000; i++) begin
      step;
      reset = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 2) != 0, $urandom_range(0, 1),
          {22'b0, 8'($urandom), 2'b0}, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 1),
          {22'b0, 8'($urandom), 2'b0}, $urandom,
          $urandom_range(0, 5) == 0);
    end
    step;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
